// File: rtl/mod_check_sched.sv
// mod_check_sched: round-robin arbiter sharing one bit-serial mod-DIVISOR engine among NREQ requesters.
module mod_check_sched #(
   parameter int NREQ = 4,
   parameter int WIDTH = 8,
   parameter int DIVISOR = 5,
   localparam int IW = $clog2(NREQ),
   localparam int RW = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  done,
   output logic [IW-1:0]         done_id,
   output logic                  done_div,
   output logic [RW-1:0]         done_rem
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [RW:0] DIV_T = (RW + 1)'(DIVISOR);

   generate
      if (DIVISOR < 2) begin : g_bad_divisor
         $error("DIVISOR must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            r_state, w_state_nx;
   logic [IW-1:0]     r_last, r_id, r_done_id, w_win;
   logic [WIDTH-1:0]  r_sh;
   logic [CW-1:0]     r_cnt;
   logic [RW-1:0]     r_res, r_rem, w_res_nx;
   logic [RW:0]       w_t, w_sub;
   logic [NREQ-1:0]   r_gnt;
   logic              r_div, w_found, w_arb, w_last_bit;

   // Round-robin search starting just past the previous winner.
   always_comb begin
      w_found = 1'b0;
      w_win = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && req[(int'(r_last) + k) % NREQ]) begin
            w_found = 1'b1;
            w_win = IW'((int'(r_last) + k) % NREQ);
         end
      end
   end

   always_comb begin
      w_arb = (r_state != S_SHIFT) && w_found;
      w_last_bit = (r_cnt == CW'(1));
      w_t = {r_res, r_sh[WIDTH-1]};
      w_sub = w_t - DIV_T;
      w_res_nx = (w_t >= DIV_T) ? w_sub[RW-1:0] : w_t[RW-1:0];
      w_state_nx = w_arb ? S_SHIFT :
                   (r_state == S_SHIFT) ? (w_last_bit ? S_DONE : S_SHIFT) : S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_last <= IW'(NREQ - 1);
         r_id <= '0;
         r_done_id <= '0;
         r_sh <= '0;
         r_cnt <= '0;
         r_res <= '0;
         r_rem <= '0;
         r_div <= 1'b0;
         r_gnt <= '0;
      end else begin
         r_state <= w_state_nx;
         r_gnt <= w_arb ? (NREQ'(1) << w_win) : '0;
         if (w_arb) begin
            r_sh <= data[w_win*WIDTH +: WIDTH];
            r_res <= '0;
            r_cnt <= CW'(WIDTH);
            r_last <= w_win;
            r_id <= w_win;
         end else if (r_state == S_SHIFT) begin
            r_res <= w_res_nx;
            r_sh <= r_sh << 1;
            r_cnt <= r_cnt - CW'(1);
            if (w_last_bit) begin
               r_done_id <= r_id;
               r_div <= (w_res_nx == '0);
               r_rem <= w_res_nx;
            end
         end
      end
   end

   assign gnt = r_gnt;
   assign busy = (r_state == S_SHIFT);
   assign done = (r_state == S_DONE);
   assign done_id = r_done_id;
   assign done_div = r_div;
   assign done_rem = r_rem;
endmodule

// File: tb/tb_mod_check_sched.sv
// tb_mod_check_sched: scoreboard bench; stimulus queues expected grants/results, a monitor compares them.
module tb_mod_check_sched;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] data = '0;
   logic [3:0]  gnt;
   logic        busy, done, done_div;
   logic [1:0]  done_id;
   logic [2:0]  done_rem;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int gnt_cyc = 0;
   int gq[$];
   logic [5:0] dq[$];
   int gcyc[$];
   int dcyc[$];

   mod_check_sched #(.NREQ(4), .WIDTH(8), .DIVISOR(5)) dut (
      .clk(clk), .resetn(resetn), .req(req), .data(data), .gnt(gnt), .busy(busy),
      .done(done), .done_id(done_id), .done_div(done_div), .done_rem(done_rem)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (resetn) begin
         cyc++;
         if (gnt != 0) begin
            checks++;
            if ($countones(gnt) != 1 || done || !busy) begin
               errors++;
               $display("FAIL gnt_excl: gnt=%b done=%b busy=%b, required one-hot gnt, done=0, busy=1", gnt, done, busy);
            end
            checks++;
            if (gq.size() == 0) begin
               errors++;
               $display("FAIL gnt_unexpected: gnt=%b, required no grant", gnt);
            end else begin
               int e;
               e = gq.pop_front();
               if (gnt != 4'(1 << e)) begin
                  errors++;
                  $display("FAIL gnt_id: gnt=%b, required requester %0d", gnt, e);
               end
            end
            gnt_cyc = cyc;
            gcyc.push_back(cyc);
         end
         if (done) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: id=%0d rem=%0d, required no done", done_id, done_rem);
            end else begin
               logic [5:0] e;
               e = dq.pop_front();
               if ({done_id, done_div, done_rem} != e || busy) begin
                  errors++;
                  $display("FAIL done_result: id=%0d div=%0d rem=%0d busy=%0d, required id=%0d div=%0d rem=%0d busy=0",
                           done_id, done_div, done_rem, busy, e[5:4], e[3], e[2:0]);
               end
            end
            checks++;
            if (cyc - gnt_cyc != 8) begin
               errors++;
               $display("FAIL done_latency: %0d cycles after gnt, required 8", cyc - gnt_cyc);
            end
            dcyc.push_back(cyc);
         end
      end
   end

   task automatic wait_gnt(output logic [3:0] g);
      g = '0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (gnt != 0) begin
            g = gnt;
            return;
         end
      end
      errors++;
      checks++;
      $display("FAIL gnt_timeout: gnt=%b, required a grant within 60 cycles", gnt);
   endtask

   task automatic drain(input int n);
      logic [3:0] g;
      for (int i = 0; i < n; i++) begin
         wait_gnt(g);
         req = req & ~g;
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (gq.size() == 0 && dq.size() == 0 && !busy && !done) return;
      end
      errors++;
      checks++;
      $display("FAIL idle_timeout: gq=%0d dq=%0d pending, required all drained", gq.size(), dq.size());
   endtask

   task automatic single(input int id, input logic [7:0] w, input logic div, input logic [2:0] rem);
      @(negedge clk);
      data[id*8 +: 8] = w;
      req[id] = 1'b1;
      gq.push_back(id);
      dq.push_back({2'(id), div, rem});
      drain(1);
      wait_idle();
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({gnt, busy, done, done_id, done_div, done_rem} != '0) begin
         errors++;
         $display("FAIL %s: gnt=%b busy=%b done=%b id=%0d div=%b rem=%0d, required all 0",
                  name, gnt, busy, done, done_id, done_div, done_rem);
      end
   endtask

   initial begin
      #1 check_zero("reset_state");
      @(negedge clk) resetn = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("idle_after_reset");
      single(1, 8'd35, 1'b1, 3'd0);
      single(0, 8'd7, 1'b0, 3'd2);
      single(0, 8'd255, 1'b1, 3'd0);
      single(0, 8'd0, 1'b1, 3'd0);
      single(0, 8'd254, 1'b0, 3'd4);
      // Mid-run asynchronous reset: outputs clear between edges, job is lost.
      @(negedge clk);
      data[31:24] = 8'd7;
      req = 4'b1000;
      gq.push_back(3);
      drain(1);
      @(negedge clk);
      checks++;
      if (!busy || done_rem != 3'd4) begin
         errors++;
         $display("FAIL pre_reset: busy=%b rem=%0d, required busy=1 rem=4", busy, done_rem);
      end
      #2 resetn = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk) resetn = 1'b1;
      repeat (12) @(negedge clk);
      check_zero("idle_after_release");
      // All four requesting from reset.
      @(negedge clk) resetn = 1'b0;
      data = {8'd20, 8'd13, 8'd100, 8'd9};
      req = 4'b1111;
      gq = '{0, 1, 2, 3};
      dq = '{{2'd0, 1'b0, 3'd4}, {2'd1, 1'b1, 3'd0}, {2'd2, 1'b0, 3'd3}, {2'd3, 1'b1, 3'd0}};
      gcyc = '{};
      dcyc = '{};
      @(negedge clk) resetn = 1'b1;
      drain(4);
      wait_idle();
      checks++;
      if (gcyc.size() != 4 || dcyc.size() != 4) begin
         errors++;
         $display("FAIL rr_count: gnts=%0d dones=%0d, required 4 and 4", gcyc.size(), dcyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (gcyc[k+1] - gcyc[k] != 9 || gcyc[k+1] - dcyc[k] != 1) begin
               errors++;
               $display("FAIL rr_spacing%0d: gnt gap=%0d done-to-gnt=%0d, required 9 and 1",
                        k, gcyc[k+1] - gcyc[k], gcyc[k+1] - dcyc[k]);
            end
         end
      end
      // Fairness: after requester 2 wins, 3 outranks 0.
      single(2, 8'd13, 1'b0, 3'd3);
      @(negedge clk);
      data = {8'd33, 16'd0, 8'd10};
      req = 4'b1001;
      gq.push_back(3);
      gq.push_back(0);
      dq.push_back({2'd3, 1'b0, 3'd3});
      dq.push_back({2'd0, 1'b1, 3'd0});
      drain(2);
      wait_idle();
      // Reset in the 4th shift cycle discards the job and restores priority.
      @(negedge clk);
      data[23:16] = 8'd3;
      req = 4'b0100;
      gq.push_back(2);
      drain(1);
      repeat (3) @(posedge clk);
      #2 resetn = 1'b0;
      #1 check_zero("reset_in_shift");
      @(negedge clk);
      data = {8'd99, 8'd0, 8'd47, 8'd0};
      req = 4'b1010;
      gq.push_back(1);
      gq.push_back(3);
      dq.push_back({2'd1, 1'b0, 3'd2});
      dq.push_back({2'd3, 1'b0, 3'd4});
      @(negedge clk) resetn = 1'b1;
      drain(2);
      wait_idle();
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mod_check_sched.md
# mod_check_sched

Round-robin scheduler that shares one bit-serial divisibility engine among several requesters. Each requester presents a parallel word. The block grants one requester at a time and streams that word MSB-first through an internal residue engine, computing `r <- (2r + bit) mod DIVISOR`. It then reports whether the word is divisible, plus the remainder and the requester id. It sits between the parallel-word clients and the serial residue datapath, and owns arbitration, sequencing and result return.

## Interface
- `NREQ`, default 4: number of requesters, 2 or more.
- `WIDTH`, default 8: bits per word, 1 or more.
- `DIVISOR`, default 5: modulus, 2 or more. Elaboration error if less than 2.
- `IW = $clog2(NREQ)`, `RW = max(1, $clog2(DIVISOR))`: derived widths.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset. **Asynchronous and active-low.**
- `req`  in  NREQ  per-requester request level.
- `data`  in  NREQ*WIDTH  word for requester i at `[i*WIDTH +: WIDTH]`.
- `gnt`  out  NREQ  one-hot grant, one-cycle pulse.
- `busy`  out  1  high while a job is shifting.
- `done`  out  1  one-cycle result strobe.
- `done_id`  out  IW  requester index of the reported job.
- `done_div`  out  1  word mod DIVISOR == 0.
- `done_rem`  out  RW  word mod DIVISOR.

## Operation
- **States:**
  - IDLE: no job.
  - SHIFT: streaming the word.
  - DONE: reporting the result.
- **Arbitration:**
  - Occurs on a clock edge in IDLE or DONE when `req != 0`.
  - The winner is the first set `req` bit, searching from `last+1` upward with wrap to 0.
  - `last` resets to NREQ-1, so requester 0 has first priority after reset.
- **On arbitration:**
  - Capture the winner's `data` into the shift register.
  - Set `residue = 0` and `cnt = WIDTH`.
  - Set `last = winner`, latch `id = winner`.
  - Go to SHIFT.
- **IDLE / DONE with `req == 0`:** go to (or stay in) IDLE.
- **SHIFT, each edge:**
  - `b` is the shift-register MSB.
  - `t = 2*residue + b`, computed at RW+1 bits.
  - `residue = t - DIVISOR` if `t >= DIVISOR`, else `t`. One conditional subtract is enough, since `residue < DIVISOR`.
  - Shift left by one; decrement `cnt`.
  - When `cnt` reaches 1 on this edge, go to DONE.
- **Result outputs:**
  - `done_id`, `done_div` and `done_rem` are loaded on the edge entering DONE.
  - They hold until the next DONE entry.
- **Requester protocol:**
  - Hold `req` and `data` stable until `gnt[i]` is seen.
  - Drop `req` in the `gnt` cycle, or assert it again later for a new job.
  - `data` is don't-care after the arbitration edge.
- **Ignored inputs:** `req` bits are ignored while in SHIFT. There is no queueing inside the block.
- **Reset (asynchronous):**
  - Clears the state to IDLE, `last = NREQ-1`, and `cnt`, `residue` and the shift register to 0.
  - All outputs go to 0 immediately: `gnt`, `busy`, `done`, `done_id`, `done_div`, `done_rem`.
  - A job in flight is discarded with no `done`. The requester already dropped `req`, so that job is lost by design.

## Timing
- **Arbitration edge E0:** `gnt[winner]=1` and `busy=1` in the cycle after E0 (the first SHIFT cycle). `gnt` is registered and never combinational from `req`.
- **Shift edges:** E1..E_WIDTH. `busy` stays high through the cycle after E_(WIDTH-1).
- **Result:** `done=1` in the cycle after E_WIDTH, for exactly one cycle, with `busy=0`.
- **Back-to-back jobs:**
  - If `req != 0` in the DONE cycle, the edge leaving DONE is the next arbitration edge.
  - The next `gnt` coincides with the cycle after `done`.
  - Sustained throughput is one job per WIDTH+1 cycles.
- **Latency:** from `req` seen in IDLE to `done` is WIDTH+1 cycles after the arbitration edge.
- **Exclusivity:** `gnt` and `done` are never high in the same cycle, and at most one `gnt` bit is set.
- **Reset release:** the first arbitration can occur on the first edge with `resetn=1`.

## Test plan
Parameters for all scenarios: NREQ=4, WIDTH=8, DIVISOR=5.

1. Assert `resetn=0` mid-run -> all outputs 0 without a clock edge; after release, idle with no `gnt`.
2. `req=4'b0010`, `data[1]=8'd35` -> `gnt=4'b0010` one cycle; `done` 8 cycles later with `done_id=1`, `done_div=1`, `done_rem=0`.
3. Single jobs on requester 0:
   - `8'd7` -> `done_rem=2`, `done_div=0`.
   - `8'd255` -> `done_rem=0`, `done_div=1`.
   - `8'd0` -> `done_rem=0`, `done_div=1`.
   - `8'd254` -> `done_rem=4`, `done_div=0`.
4. `req=4'b1111` from reset, each held until its `gnt`:
   - Grants come in order 0, 1, 2, 3, spaced 9 cycles apart.
   - Each `done` precedes the next `gnt` by one cycle.
   - `done_id` values are 0, 1, 2, 3.
5. Fairness after a grant to 2: `req=4'b1001` -> requester 3 is granted before 0.
6. Reset asserted on the 4th SHIFT cycle of a job -> no `done` for that job. After release, `req=4'b1010` -> requester 1 is granted, because `last` was reset to 3.
